// File: rtl/serializer_32_if.sv
// Handshake/data bundle between a parallel word source and serializer_32.
// The master drives load/D; the serializer drives the serial stream and its status.
interface serializer_32_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic [WIDTH-1:0] D;
  logic             S;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (output load, D, input S, valid, busy, done);
  modport slave  (input load, D, output S, valid, busy, done);
endinterface

// File: rtl/serializer_32.sv
// Parallel-in, MSB-first serial-out unloader with valid/busy/done status.
// Optional trailing even-parity bit is compiled in with `define SERIALIZER_PARITY_EN.
module serializer_32 #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  serializer_32_if.slave bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2, ST_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd3} state_t;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_count;
`ifdef SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Word is captured only in IDLE; later loads and D changes cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_count <= '0;
`ifdef SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_shreg <= bus.D;
            r_count <= '0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_count <= r_count + 1'b1;
`ifdef SERIALIZER_PARITY_EN
          r_par   <= r_par ^ r_shreg[WIDTH-1];
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    bus.S        = 1'b0;
    bus.valid    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        bus.S     = r_shreg[WIDTH-1];
        bus.valid = 1'b1;
        bus.busy  = 1'b1;
        if (r_count == LAST) begin
`ifdef SERIALIZER_PARITY_EN
          w_next_state = ST_PAR;
`else
          w_next_state = ST_DONE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PAR: begin
        // Accumulator holds the XOR of all WIDTH shifted bits by now.
        bus.S        = r_par;
        bus.valid    = 1'b1;
        bus.busy     = 1'b1;
        w_next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        bus.done     = 1'b1;
        bus.busy     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_serializer_32.sv
// Scoreboard bench for serializer_32: expected bits are queued at load time and
// popped by a negedge monitor whenever valid is high.
module tb_serializer_32;
  localparam int WIDTH      = 32;
  localparam int CLK_PERIOD = 20;
`ifdef SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = WIDTH + PB;     // cycles with valid=1 per word
  localparam int P     = WIDTH + 2 + PB; // load-to-load spacing

  logic clk = 1'b0;
  logic reset;

  serializer_32_if #(.WIDTH(WIDTH)) bus ();
  serializer_32 #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #(CLK_PERIOD/2) clk = ~clk;

  bit exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int v_cnt = 0;
  int d_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) begin
        v_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra: got valid bit S=%0b, required no valid bit", bus.S);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (bus.S !== e) begin
            n_err++;
            $display("FAIL stream_bit: S=%0b, required %0b (t=%0t)", bus.S, e, $time);
          end
        end
      end
      if (bus.done) d_cnt++;
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  task automatic start_word(input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.D    = d;
    bus.load = 1'b1;
    push_word(d);
  endtask

  task automatic test_reset;
    #10;
    n_cmp++;
    if ({bus.S, bus.valid, bus.busy, bus.done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: S/valid/busy/done=%b, required 0000", {bus.S, bus.valid, bus.busy, bus.done});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    int v0, d0;
    v0 = v_cnt; d0 = d_cnt;
    start_word(32'h80000001);
    for (int k = 0; k <= P; k++) begin
      @(negedge clk);
      if (k == 0) bus.load = 1'b0;
      if (k == FRAME - 1) begin
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL single_last_bit: valid=%b done=%b, required 1 0", bus.valid, bus.done);
        end
      end
      if (k == FRAME) begin
        n_cmp++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_done: done=%b valid=%b busy=%b, required 1 0 1", bus.done, bus.valid, bus.busy);
        end
      end
      if (k == FRAME + 1) begin
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL single_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
      end
    end
    #1;
    n_cmp++;
    if (v_cnt - v0 != FRAME) begin
      n_err++;
      $display("FAIL single_valid_count: %0d, required %0d", v_cnt - v0, FRAME);
    end
    n_cmp++;
    if (d_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL single_done_count: %0d, required 1", d_cnt - d0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_leftover: %0d bits unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_ignore_load;
    int v0, d0;
    v0 = v_cnt; d0 = d_cnt;
    start_word(32'hA5A5A5A5);
    for (int k = 0; k <= P + 1; k++) begin
      @(negedge clk);
      if (k == 0) bus.load = 1'b0;
      if (k == 5) begin
        bus.load = 1'b1;
        bus.D    = 32'hFFFFFFFF;
      end
      if (k == FRAME) begin
        n_cmp++;
        if (bus.done !== 1'b1) begin
          n_err++;
          $display("FAIL ignore_done: done=%b, required 1", bus.done);
        end
        bus.load = 1'b0;
      end
      if (k > FRAME) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL ignore_restart: busy=%b at k=%0d, required 0", bus.busy, k);
        end
      end
    end
    #1;
    n_cmp++;
    if (v_cnt - v0 != FRAME || d_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ignore_counts: valid=%0d done=%0d left=%0d, required %0d 1 0",
               v_cnt - v0, d_cnt - d0, exp_q.size(), FRAME);
    end
  endtask

  task automatic test_reset_abort;
    int v0, d0;
    start_word(32'hFFFF0000);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.load = 1'b0;
    end
    #5;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.S, bus.valid, bus.busy, bus.done} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_outputs: S/valid/busy/done=%b, required 0000", {bus.S, bus.valid, bus.busy, bus.done});
    end
    exp_q.delete();
    v0 = v_cnt; d0 = d_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || v_cnt != v0 || d_cnt != d0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b valid_cycles=%0d done_pulses=%0d, required 0 0 0",
               bus.busy, v_cnt - v0, d_cnt - d0);
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity;
    logic [WIDTH-1:0] words [2];
    int v0, d0;
    words[0] = 32'h00000007;
    words[1] = 32'h00000003;
    for (int w = 0; w < 2; w++) begin
      v0 = v_cnt; d0 = d_cnt;
      start_word(words[w]);
      for (int k = 0; k <= P; k++) begin
        @(negedge clk);
        if (k == 0) bus.load = 1'b0;
        if (k == WIDTH) begin
          n_cmp++;
          if (bus.valid !== 1'b1 || bus.S !== ^words[w]) begin
            n_err++;
            $display("FAIL parity_bit: valid=%b S=%b, required 1 %b", bus.valid, bus.S, ^words[w]);
          end
        end
      end
      #1;
      n_cmp++;
      if (v_cnt - v0 != FRAME || d_cnt - d0 != 1) begin
        n_err++;
        $display("FAIL parity_counts: valid=%0d done=%0d, required %0d 1", v_cnt - v0, d_cnt - d0, FRAME);
      end
    end
  endtask
`endif

  task automatic test_back_to_back;
    int v0, d0;
    v0 = v_cnt; d0 = d_cnt;
    @(negedge clk);
    bus.D    = 32'h12345678;
    bus.load = 1'b1;
    for (int n = 0; n < 3; n++) push_word(32'h12345678);
    for (int k = 0; k <= 3 * P + 2; k++) begin
      @(negedge clk);
      if (k == 2 * P + 1) bus.load = 1'b0;
      if (k % P == 0 && k < 3 * P) begin
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_start: valid=%b busy=%b at k=%0d, required 1 1", bus.valid, bus.busy, k);
        end
      end
      if (k % P == P - 1 || k >= 3 * P - 1) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_gap: busy=%b at k=%0d, required 0", bus.busy, k);
        end
      end
    end
    #1;
    n_cmp++;
    if (v_cnt - v0 != 3 * FRAME || d_cnt - d0 != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_counts: valid=%0d done=%0d left=%0d, required %0d 3 0",
               v_cnt - v0, d_cnt - d0, exp_q.size(), 3 * FRAME);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.D    = '0;
    test_reset;
    test_single;
    test_ignore_load;
    test_reset_abort;
`ifdef SERIALIZER_PARITY_EN
    test_parity;
`endif
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
